byte_port_shifter: RTL and testbench
====================================

Name: byte_port_shifter

Overview:
- Downstream consumer of the CPU byte output port (the `out_byte` / `out_byte_en` strobe pair in the system top).
- Buffers each strobed byte in a small FIFO.
- Serialises each byte to an external 74HC595-style shift register chain: data, shift clock, latch clock.
- Lets firmware write bytes back-to-back without waiting on the slow serial link.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- CLK_DIV, 4, clk cycles per half period of srclk_o and width of the rclk_o pulse; minimum 1.

Ports:
- clk  input  1  system clock
- resetn  input  1  reset, asynchronous, active-low
- byte_i  input  8  byte from the CPU output port
- byte_en_i  input  1  one-cycle write strobe for byte_i
- ser_o  output  1  serial data, MSB first
- srclk_o  output  1  shift clock; the external device samples ser_o on its rising edge
- rclk_o  output  1  storage latch pulse, high for CLK_DIV cycles after each byte
- busy_o  output  1  high when the FSM is not IDLE or the FIFO is not empty
- full_o  output  1  FIFO count == DEPTH
- empty_o  output  1  FIFO count == 0
- ovf_o  output  1  sticky flag: a strobe was dropped

Behaviour:
- Clock and reset: clk is the clock; resetn is the reset, asynchronous, active-low.
- Reset values: ser_o=0, srclk_o=0, rclk_o=0, busy_o=0, full_o=0, empty_o=1, ovf_o=0. FIFO pointers and count are 0, FSM is IDLE, divider and bit counters are 0.
- Reset mid-operation: the current transfer is aborted and all buffered bytes are discarded.
- All outputs are registered.
- FIFO push: on byte_en_i=1, accepted when count<DEPTH, or when a pop occurs in the same cycle.
  - If full with no pop: byte dropped, ovf_o set to 1. It stays 1 until reset.
  - Simultaneous push+pop: count unchanged.
  - Pointers wrap modulo DEPTH.
  - Count is log2(DEPTH)+1 bits wide.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
  - IDLE: ser_o=0, srclk_o=0, rclk_o=0. If !empty, go to LOAD next cycle.
  - LOAD (1 cycle): pop the FIFO head into the 8-bit shift register, set ser_o=head[7], bit counter=0, go to SHIFT_LO.
  - SHIFT_LO: srclk_o=0 for CLK_DIV cycles, then SHIFT_HI.
  - SHIFT_HI: srclk_o=1 for CLK_DIV cycles.
    - On exit: shift register shifts left by one, ser_o takes the new bit 7, bit counter increments.
    - If the counter reaches 8, go to LATCH; otherwise go to SHIFT_LO.
  - LATCH: srclk_o=0, rclk_o=1 for CLK_DIV cycles, then IDLE.
- ser_o only changes while srclk_o is low, or on the srclk_o falling edge. It is stable for the whole high phase.
- Per-byte time from IDLE (FIFO non-empty) back to IDLE: 2 + 16*CLK_DIV + CLK_DIV cycles. This is 70 cycles at CLK_DIV=4.
- Latency: a byte strobed into an empty FIFO with the FSM in IDLE is popped (LOAD) 2 cycles after the strobe cycle.
- Data passes through unmodified; no inversion is applied.
- busy_o = (state!=IDLE) or !empty, registered. It is low only when fully drained.

Optional Feature:
- Macro: BYTE_SHIFT_OVF_CNT_EN.
- Defined:
  - Adds output port ovf_cnt_o, 8 bits.
  - Counts dropped strobes and saturates at 255.
  - Reset value is 0.
  - ovf_o remains and equals (ovf_cnt_o!=0).
- Undefined:
  - No port and no counter.
  - Only the sticky ovf_o is present.

Test Plan:
- Single byte 0xA5, CLK_DIV=4 -> ser_o sampled at the 8 srclk_o rising edges = 1,0,1,0,0,1,0,1.
  - One rclk_o pulse of exactly 4 cycles.
  - busy_o low again 72 cycles after the strobe; empty_o=1.
- Strobes on 10 consecutive cycles with values 0x00..0x09, DEPTH=8, CLK_DIV=4 -> bytes 0x00..0x08 are shifted out in order.
  - 0x09 is dropped; ovf_o=1 from the cycle after its strobe.
  - full_o=1 during the strobe of 0x09.
- Push and pop in the same cycle while full: keep the FIFO full, strobe 0x3C in the LOAD cycle -> accepted, count stays 8, ovf_o stays 0, 0x3C emitted last.
- Assert resetn=0 asynchronously mid SHIFT_HI of byte 0x81 with 3 bytes queued -> all outputs return to their reset values immediately, with no clk edge needed.
  - After release, no further srclk_o or rclk_o activity; empty_o=1.
- Pointer wrap: 20 bytes strobed one every 80 cycles -> all 20 emitted in order, none dropped, ovf_o=0.
- With BYTE_SHIFT_OVF_CNT_EN: strobe 300 bytes while full -> ovf_cnt_o saturates at 255 and ovf_o=1. Without the macro, the bench checks that the port is absent.

Source files
------------

// File: rtl/byte_port_shifter.sv
// Byte output-port FIFO feeding a 74HC595-style serial chain (ser/srclk/rclk).
// Optional dropped-strobe counter port ovf_cnt_o when BYTE_SHIFT_OVF_CNT_EN is defined.
module byte_port_shifter #(
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [7:0] byte_i,
   input  logic       byte_en_i,
   output logic       ser_o,
   output logic       srclk_o,
   output logic       rclk_o,
   output logic       busy_o,
   output logic       full_o,
   output logic       empty_o,
   output logic       ovf_o
`ifdef BYTE_SHIFT_OVF_CNT_EN
   ,
   output logic [7:0] ovf_cnt_o
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DivLast = DW'(CLK_DIV - 1);
   localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StLoad    = 3'd1;
   localparam logic [2:0] StShiftLo = 3'd2;
   localparam logic [2:0] StShiftHi = 3'd3;
   localparam logic [2:0] StLatch   = 3'd4;

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [2:0]    state_q, state_d;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          ser_q, ser_d, srclk_q, srclk_d, rclk_q, rclk_d;
   logic          busy_q, busy_d, full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
   logic          push, pop, drop;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts during LOAD.
   always_comb begin
      pop      = (state_q == StLoad);
      push     = byte_en_i && ((count_q != CntFull) || pop);
      drop     = byte_en_i && !push;
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
      full_d   = (count_d == CntFull);
      empty_d  = (count_d == '0);
      busy_d   = (state_q != StIdle) || (count_q != '0);
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      ser_d   = ser_q;
      case (state_q)
         StIdle: begin
            ser_d = 1'b0;
            if (count_q != '0) state_d = StLoad;
         end
         StLoad: begin
            shreg_d = mem_q[rd_ptr_q];
            ser_d   = mem_q[rd_ptr_q][7];
            bit_d   = 4'd0;
            div_d   = '0;
            state_d = StShiftLo;
         end
         StShiftLo: begin
            if (div_q == DivLast) begin
               div_d   = '0;
               state_d = StShiftHi;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StShiftHi: begin
            // Data advances together with the srclk falling edge, never while high.
            if (div_q == DivLast) begin
               div_d   = '0;
               shreg_d = {shreg_q[6:0], 1'b0};
               ser_d   = shreg_q[6];
               bit_d   = bit_q + 4'd1;
               state_d = (bit_q == 4'd7) ? StLatch : StShiftLo;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StLatch: begin
            if (div_q == DivLast) begin
               div_d   = '0;
               state_d = StIdle;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
      srclk_d = (state_d == StShiftHi);
      rclk_d  = (state_d == StLatch);
   end

`ifdef BYTE_SHIFT_OVF_CNT_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
      ovf_d = (ovf_cnt_d != 8'd0);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) ovf_cnt_q <= 8'd0;
      else         ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_cnt_o = ovf_cnt_q;
`else
   always_comb ovf_d = ovf_q | drop;
`endif

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= byte_i;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= StIdle;
         div_q    <= '0;
         bit_q    <= 4'd0;
         shreg_q  <= 8'd0;
         ser_q    <= 1'b0;
         srclk_q  <= 1'b0;
         rclk_q   <= 1'b0;
         busy_q   <= 1'b0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         ser_q    <= ser_d;
         srclk_q  <= srclk_d;
         rclk_q   <= rclk_d;
         busy_q   <= busy_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
      end
   end

   assign ser_o   = ser_q;
   assign srclk_o = srclk_q;
   assign rclk_o  = rclk_q;
   assign busy_o  = busy_q;
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_byte_port_shifter.sv
// Bench for byte_port_shifter: timing-level FIFO/service model plus a serial-link monitor.
// Exercises ovf_cnt_o only when BYTE_SHIFT_OVF_CNT_EN is defined.
module tb_byte_port_shifter;

   localparam int DEPTH   = 8;
   localparam int CLK_DIV = 4;
   // Cycles a byte occupies the shifter after its IDLE cycle: LOAD + 16 half periods + latch.
   localparam int SVC     = 1 + 16 * CLK_DIV + CLK_DIV;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] byte_i = 8'd0;
   logic       byte_en_i = 1'b0;
   logic       ser_o, srclk_o, rclk_o, busy_o, full_o, empty_o, ovf_o;
`ifdef BYTE_SHIFT_OVF_CNT_EN
   logic [7:0] ovf_cnt_o;
`endif

   byte_port_shifter #(
      .DEPTH   (DEPTH),
      .CLK_DIV (CLK_DIV)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .byte_i    (byte_i),
      .byte_en_i (byte_en_i),
      .ser_o     (ser_o),
      .srclk_o   (srclk_o),
      .rclk_o    (rclk_o),
      .busy_o    (busy_o),
      .full_o    (full_o),
      .empty_o   (empty_o),
      .ovf_o     (ovf_o)
`ifdef BYTE_SHIFT_OVF_CNT_EN
      ,
      .ovf_cnt_o (ovf_cnt_o)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: FIFO contents, remaining service cycles, sticky flags.
   logic [7:0] mq[$];
   logic [7:0] exp_q[$];
   int         svc = 0;
   logic       m_ovf = 1'b0;
   logic       m_busy = 1'b0;
   int         m_cnt = 0;

   // Monitor state.
   int         nbits = 0, n_rise = 0, n_rclk = 0, n_rx = 0, rwidth = 0;
   logic [7:0] acc = 8'd0, last_rx = 8'd0, want;
   logic       sr_prev = 1'b0, ser_prev = 1'b0, rclk_prev = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_update(input logic en, input logic [7:0] b);
      logic pop;
      int   sz;
      pop    = (svc == SVC);
      sz     = mq.size();
      m_busy = (svc > 0) || (sz > 0);
      if (pop) void'(mq.pop_front());
      if (en) begin
         if (sz < DEPTH || pop) begin
            mq.push_back(b);
            exp_q.push_back(b);
         end else begin
            m_ovf = 1'b1;
            if (m_cnt < 255) m_cnt++;
         end
      end
      if (svc > 0) svc--;
      else if (sz > 0) svc = SVC;
   endtask

   task automatic model_reset();
      mq.delete();
      exp_q.delete();
      svc    = 0;
      m_ovf  = 1'b0;
      m_busy = 1'b0;
      m_cnt  = 0;
   endtask

   // One clock cycle: drive, check flags mid-cycle against the model, advance the model.
   task automatic step(input logic en, input logic [7:0] b);
      byte_en_i = en;
      byte_i    = b;
      @(negedge clk);
      chk("full",  32'(full_o),  32'(mq.size() == DEPTH));
      chk("empty", 32'(empty_o), 32'(mq.size() == 0));
      chk("ovf",   32'(ovf_o),   32'(m_ovf));
      chk("busy",  32'(busy_o),  32'(m_busy));
`ifdef BYTE_SHIFT_OVF_CNT_EN
      chk("ovf_cnt", 32'(ovf_cnt_o), 32'(m_cnt));
`endif
      model_update(en, b);
      @(posedge clk);
      #1;
      byte_en_i = 1'b0;
   endtask

   task automatic drain();
      int i;
      i = 0;
      while (!(svc == 0 && mq.size() == 0) && i < 3000) begin
         step(1'b0, 8'd0);
         i++;
      end
      chk("drain_bound", 32'(i < 3000), 32'd1);
      repeat (3) step(1'b0, 8'd0);
      chk("drain_rx_all", 32'(exp_q.size()), 32'd0);
   endtask

   // Serial monitor: assembles bytes on srclk rising edges, checks stability and latch width.
   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            nbits = 0; sr_prev = 1'b0; ser_prev = 1'b0; rclk_prev = 1'b0; rwidth = 0;
         end else begin
            if (srclk_o === 1'b1 && sr_prev === 1'b0) begin
               acc = {acc[6:0], ser_o};
               nbits++;
               n_rise++;
               if (nbits == 8) begin
                  nbits   = 0;
                  n_rx++;
                  last_rx = acc;
                  if (exp_q.size() == 0) chk("rx_unexpected", 32'(acc), 32'hFFFF_FFFF);
                  else begin
                     want = exp_q.pop_front();
                     chk("rx_byte", 32'(acc), 32'(want));
                  end
               end
            end else if (srclk_o === 1'b1) begin
               chk("ser_stable", 32'(ser_o), 32'(ser_prev));
            end
            if (rclk_o === 1'b1) rwidth++;
            else if (rclk_prev === 1'b1) begin
               n_rclk++;
               chk("rclk_width", 32'(rwidth), 32'(CLK_DIV));
               chk("latch_bits", 32'(nbits), 32'd0);
               rwidth = 0;
            end
            sr_prev = srclk_o; ser_prev = ser_o; rclk_prev = rclk_o;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rx0, rc0, rs0, guard;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ser",   32'(ser_o),   32'd0);
      chk("rst_srclk", 32'(srclk_o), 32'd0);
      chk("rst_rclk",  32'(rclk_o),  32'd0);
      chk("rst_busy",  32'(busy_o),  32'd0);
      chk("rst_full",  32'(full_o),  32'd0);
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_ovf",   32'(ovf_o),   32'd0);
      resetn = 1'b1;
      repeat (2) step(1'b0, 8'd0);

      // Single byte 0xA5.
      rx0 = n_rx; rc0 = n_rclk;
      step(1'b1, 8'hA5);
      repeat (69) step(1'b0, 8'd0);
      chk("t1_busy70", 32'(busy_o), 32'd1);
      repeat (2) step(1'b0, 8'd0);
      chk("t1_busy72", 32'(busy_o), 32'd0);
      chk("t1_empty",  32'(empty_o), 32'd1);
      chk("t1_rx",     32'(last_rx), 32'hA5);
      chk("t1_nrx",    32'(n_rx - rx0), 32'd1);
      chk("t1_nrclk",  32'(n_rclk - rc0), 32'd1);
      drain();

      // Push and pop in the same cycle while full.
      rx0 = n_rx;
      for (int i = 0; i < 9; i++) step(1'b1, 8'($urandom));
      guard = 0;
      while (svc != SVC && guard < 200) begin
         step(1'b0, 8'd0);
         guard++;
      end
      chk("t3_load_found", 32'(guard < 200), 32'd1);
      chk("t3_full_pre", 32'(full_o), 32'd1);
      step(1'b1, 8'h3C);
      chk("t3_full_post", 32'(full_o), 32'd1);
      chk("t3_ovf", 32'(ovf_o), 32'd0);
      drain();
      chk("t3_last", 32'(last_rx), 32'h3C);
      chk("t3_nrx",  32'(n_rx - rx0), 32'd10);

      // Ten back-to-back strobes into an idle shifter; the tenth overflows.
      rx0 = n_rx;
      for (int i = 0; i < 10; i++) begin
         step(1'b1, 8'(i));
         if (i == 8) chk("t2_full_at_9", 32'(full_o), 32'd1);
         if (i == 9) chk("t2_ovf_after", 32'(ovf_o), 32'd1);
      end
      drain();
      chk("t2_nrx",  32'(n_rx - rx0), 32'd9);
      chk("t2_last", 32'(last_rx), 32'h08);

      // Asynchronous reset mid shift-high of 0x81 with three bytes queued.
      step(1'b1, 8'h81);
      for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom));
      guard = 0;
      while (srclk_o !== 1'b1 && guard < 20) begin
         step(1'b0, 8'd0);
         guard++;
      end
      chk("t4_srclk_hi", 32'(srclk_o), 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("t4_ser",   32'(ser_o),   32'd0);
      chk("t4_srclk", 32'(srclk_o), 32'd0);
      chk("t4_rclk",  32'(rclk_o),  32'd0);
      chk("t4_busy",  32'(busy_o),  32'd0);
      chk("t4_full",  32'(full_o),  32'd0);
      chk("t4_empty", 32'(empty_o), 32'd1);
      chk("t4_ovf",   32'(ovf_o),   32'd0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      rs0 = n_rise; rc0 = n_rclk;
      repeat (150) step(1'b0, 8'd0);
      chk("t4_no_srclk", 32'(n_rise - rs0), 32'd0);
      chk("t4_no_rclk",  32'(n_rclk - rc0), 32'd0);
      chk("t4_empty_after", 32'(empty_o), 32'd1);

      // Pointer wrap: twenty spaced bytes.
      rx0 = n_rx;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'($urandom));
         repeat (79) step(1'b0, 8'd0);
      end
      drain();
      chk("t5_nrx", 32'(n_rx - rx0), 32'd20);
      chk("t5_ovf", 32'(ovf_o), 32'd0);

      // Sustained strobes while full.
      for (int i = 0; i < 310; i++) step(1'b1, 8'($urandom));
      chk("t6_ovf", 32'(ovf_o), 32'd1);
`ifdef BYTE_SHIFT_OVF_CNT_EN
      chk("t6_cnt_sat", 32'(ovf_cnt_o), 32'd255);
`endif
      drain();

      // Random sparse traffic.
      for (int i = 0; i < 600; i++) step(1'($urandom_range(0, 29) == 0), 8'($urandom));
      drain();
      chk("final_empty", 32'(empty_o), 32'd1);
      chk("final_idle",  32'(busy_o),  32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
